// File: rtl/aes_cipher_insn_queue_pkg.sv
// Shared definitions for the AES custom-instruction request queue.
//   state_e      : issue FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   DEF_*        : default geometry (DEPTH, PTR_W, TAG_W, DATA_W, TIMEOUT)
//   entry_w()    : width of one stored request {tag, key, text}
// The DEF_TIMEOUT default only exists when AES_INSN_TIMEOUT_EN is defined.
package aes_cipher_insn_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_PTR_W  = 2;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 128;
`ifdef AES_INSN_TIMEOUT_EN
  localparam int DEF_TIMEOUT = 64;
`endif

  function automatic int entry_w(input int tag_w, input int data_w);
    return tag_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/aes_cipher_insn_queue_fifo.sv
// aes_insn_fifo: DEPTH x W request FIFO for the AES instruction queue.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset (pointers/count only)
//   push, din        : write one entry (ignored while full)
//   pop              : retire the head entry
//   flush_all        : drop every entry
//   flush_keep_head  : drop every entry except the head (combined with pop -> empty)
//   head             : current head entry
//   occupancy        : number of stored entries, 0..DEPTH
//   full, empty      : occupancy == DEPTH / occupancy == 0
module aes_insn_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 260
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  input  logic             flush_all,
  input  logic             flush_keep_head,
  output logic [W-1:0]     head,
  output logic [PTR_W:0]   occupancy,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full & ~flush_all & ~flush_keep_head;
  assign do_pop  = pop & ~empty;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_all) begin
      wr_d  = rd_q;
      cnt_d = '0;
    end else if (flush_keep_head) begin
      // The write pointer is pulled back to just behind the head; if the head
      // also retires this cycle, the queue ends up empty.
      if (!empty) begin
        if (do_pop) begin
          rd_d  = rd_q + PTR_W'(1);
          wr_d  = rd_q + PTR_W'(1);
          cnt_d = '0;
        end else begin
          wr_d  = rd_q + PTR_W'(1);
          cnt_d = (PTR_W+1)'(1);
        end
      end
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign head      = mem_q[rd_q];
  assign occupancy = cnt_q;

endmodule

// File: rtl/aes_cipher_insn_queue.sv
// aes_cipher_insn_queue: request queue and issue controller between the OR1200
// AES custom instruction and an aes_cipher_top core, single clock domain.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   req_valid/ready/tag/key/text : tagged request input (req_ready = !full)
//   flush                     : drop queued, not-yet-issued requests
//   core_ld/key/text          : one-cycle load pulse and operands to the core
//   core_done, core_text_out  : core completion pulse and result
//   rsp_valid/ready/tag/text/err : tagged response output
//   occupancy                 : entries held, in-flight head included
// Build option: AES_INSN_TIMEOUT_EN adds a core_done watchdog (parameter
// TIMEOUT); a request that times out returns rsp_err=1 with rsp_text=0.
module aes_cipher_insn_queue
  import aes_cipher_insn_queue_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = DEF_PTR_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef AES_INSN_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_key,
  input  logic [DATA_W-1:0] req_text,
  input  logic              flush,
  output logic              core_ld,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_text,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_text_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_text,
  output logic              rsp_err,
  output logic [PTR_W:0]    occupancy
);

  localparam int ENTRY_W = entry_w(TAG_W, DATA_W);

  state_e              state_q;
  logic                rsp_err_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic [DATA_W-1:0]   rsp_text_q;

  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  head;
  logic                push, pop, flush_all, flush_keep_head;
  logic                timeout;

  logic [TAG_W-1:0]    head_tag;
  logic [DATA_W-1:0]   head_key, head_text;

  assign head_tag  = head[ENTRY_W-1 -: TAG_W];
  assign head_key  = head[2*DATA_W-1 -: DATA_W];
  assign head_text = head[DATA_W-1:0];

  // A push coinciding with flush is dropped; req_ready itself only tracks full.
  assign req_ready       = ~fifo_full;
  assign push            = req_valid & ~fifo_full & ~flush;
  assign pop             = (state_q == ST_RESP) & rsp_ready;
  // Before issue the whole queue may go; once the head is in the core it must finish.
  assign flush_all       = flush & ((state_q == ST_IDLE) | (state_q == ST_ISSUE));
  assign flush_keep_head = flush & ((state_q == ST_WAIT) | (state_q == ST_RESP));

  aes_insn_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .din             ({req_tag, req_key, req_text}),
    .pop             (pop),
    .flush_all       (flush_all),
    .flush_keep_head (flush_keep_head),
    .head            (head),
    .occupancy       (occupancy),
    .full            (fifo_full),
    .empty           (fifo_empty)
  );

`ifdef AES_INSN_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wdog_q;

  // core_done in the expiry cycle wins over the timeout.
  assign timeout = (state_q == ST_WAIT) & ~core_done & (wdog_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wdog_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && !flush) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state_q <= flush ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            state_q   <= ST_RESP;
            rsp_err_q <= 1'b0;
          end else if (timeout) begin
            state_q   <= ST_RESP;
            rsp_err_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Response payload; qualified by rsp_valid on the way out, so no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == ST_WAIT) begin
      if (core_done) begin
        rsp_tag_q  <= head_tag;
        rsp_text_q <= core_text_out;
      end else if (timeout) begin
        rsp_tag_q  <= head_tag;
        rsp_text_q <= '0;
      end
    end
  end

  // core_ld is withdrawn if flush cancels the issue in the same cycle.
  assign core_ld   = (state_q == ST_ISSUE) & ~flush;
  assign core_key  = (state_q != ST_IDLE) ? head_key  : '0;
  assign core_text = (state_q != ST_IDLE) ? head_text : '0;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_tag   = rsp_valid ? rsp_tag_q  : '0;
  assign rsp_text  = rsp_valid ? rsp_text_q : '0;
  assign rsp_err   = rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_aes_cipher_insn_queue.sv
// Bench for aes_cipher_insn_queue: directed steps plus a randomized phase, all
// checked against a request-level queue model and a stub AES core.
module tb_aes_cipher_insn_queue;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 128;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [DATA_W-1:0] req_key = '0;
  logic [DATA_W-1:0] req_text = '0;
  logic              flush = 1'b0;
  logic              core_ld;
  logic [DATA_W-1:0] core_key, core_text;
  logic              core_done;
  logic [DATA_W-1:0] core_text_out;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_text;
  logic              rsp_err;
  logic [2:0]        occupancy;

  aes_cipher_insn_queue dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_key(req_key), .req_text(req_text), .flush(flush),
    .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_text(rsp_text), .rsp_err(rsp_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext, anything
  // else to a cheap keyed mix so that results remain request-specific.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == KEY0 && t == PT0) return CT0;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // Stub core: fixed latency from core_ld, operands latched at load.
  int           core_lat = 12;
  bit           core_mute = 1'b0;
  logic         inj_done = 1'b0;
  logic         stub_done = 1'b0;
  logic [127:0] stub_out = '0, stub_k = '0, stub_t = '0;
  int           stub_cnt = -1;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (core_ld) begin
      stub_cnt <= core_lat - 1;
      stub_k   <= core_key;
      stub_t   <= core_text;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 0) begin
      stub_cnt  <= -1;
      stub_done <= !core_mute;
      stub_out  <= core_fn(stub_k, stub_t);
    end
  end

  assign core_done     = stub_done | inj_done;
  assign core_text_out = stub_out;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] text;
  } req_t;

  req_t             sb[$];
  logic [TAG_W-1:0] rsp_tags[$];
  bit               in_flight = 1'b0;
  bit               exp_timeout = 1'b0;
  int               ld_cnt = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, advance the model at the edge,
  // then check the DUT against the model.
  task automatic tick();
    logic              push_acc, rsp_acc, ld, fl, hold;
    logic [TAG_W-1:0]  htag;
    logic [DATA_W-1:0] htext;
    req_t              nr;
    #1;
    push_acc = req_valid && (sb.size() < DEPTH) && !flush;
    rsp_acc  = rsp_valid && rsp_ready;
    ld       = core_ld;
    fl       = flush;
    hold     = rsp_valid && !rsp_ready;
    htag     = rsp_tag;
    htext    = rsp_text;
    nr.tag   = req_tag;
    nr.key   = req_key;
    nr.text  = req_text;
    if (ld) begin
      ld_cnt++;
      if (sb.size() == 0) chk("issue_empty", core_ld, 1'b0);
      else begin
        chk("issue_key", core_key, sb[0].key);
        chk("issue_text", core_text, sb[0].text);
      end
    end
    if (rsp_acc) begin
      rsp_tags.push_back(rsp_tag);
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
      else begin
        chk("rsp_tag", rsp_tag, sb[0].tag);
        chk("rsp_text", rsp_text, exp_timeout ? 128'h0 : core_fn(sb[0].key, sb[0].text));
        chk("rsp_err", rsp_err, exp_timeout);
      end
    end
    @(posedge clk);
    #1;
    if (fl) begin
      if (in_flight) begin
        while (sb.size() > 1) void'(sb.pop_back());
      end else sb.delete();
    end
    if (rsp_acc && sb.size() > 0) begin
      void'(sb.pop_front());
      in_flight = 1'b0;
    end
    if (ld) in_flight = 1'b1;
    if (push_acc) sb.push_back(nr);
    chk("occupancy", occupancy, sb.size());
    chk("req_ready", req_ready, sb.size() < DEPTH);
    if (hold) begin
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_tag", rsp_tag, htag);
      chk("hold_text", rsp_text, htext);
    end
    if (in_flight && sb.size() > 0) begin
      chk("flight_key", core_key, sb[0].key);
      chk("flight_text", core_text, sb[0].text);
    end else if (sb.size() == 0) begin
      chk("idle_key", core_key, 128'h0);
      chk("idle_text", core_text, 128'h0);
    end
  endtask

  task automatic push_req(input logic [TAG_W-1:0] t, input logic [127:0] k, input logic [127:0] p);
    req_valid = 1'b1;
    req_tag   = t;
    req_key   = k;
    req_text  = p;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    for (int i = 0; i < max && !rsp_valid; i++) tick();
    chk("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic drain(input int max);
    rsp_ready = 1'b1;
    for (int i = 0; i < max && (sb.size() > 0 || rsp_valid); i++) tick();
    chk("drain_done", sb.size(), 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: no finish within time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, ld0, base, spur;
    bit seen;

    // Reset values
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_core_ld", core_ld, 1'b0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_text", rsp_text, 128'h0);
    chk("rst_rsp_tag", rsp_tag, 4'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_occupancy", occupancy, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single request, FIPS-197 vector
    core_lat  = 12;
    rsp_ready = 1'b0;
    push_req(4'd3, KEY0, PT0);
    chk("single_ld_early", core_ld, 1'b0);
    tick();
    chk("single_ld", core_ld, 1'b1);
    chk("single_key", core_key, KEY0);
    chk("single_text", core_text, PT0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (core_done) begin
        seen = 1'b1;
        tick();
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_rsp_tag", rsp_tag, 4'd3);
        chk("single_rsp_text", rsp_text, CT0);
      end else tick();
    end
    chk("single_done_seen", seen, 1'b1);
    drain(10);

    // Fill to DEPTH, in-order responses
    core_lat  = $urandom_range(4, 10);
    rsp_ready = 1'b1;
    base = rsp_tags.size();
    for (int i = 0; i < DEPTH; i++) push_req(4'(i), rnd128(), rnd128());
    chk("fill_occ", occupancy, 3'd4);
    req_valid = 1'b1;
    req_tag   = 4'd4;
    #1;
    chk("fill_ready_full", req_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    drain(200);
    chk("fill_rsp_count", rsp_tags.size() - base, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (base + i < rsp_tags.size()) chk("fill_order", rsp_tags[base + i], i);

    // Backpressure
    core_lat  = 6;
    rsp_ready = 1'b0;
    push_req(4'd5, rnd128(), rnd128());
    push_req(4'd6, rnd128(), rnd128());
    wait_rsp(60);
    ld0 = ld_cnt;
    repeat (20) tick();
    chk("bp_no_ld", ld_cnt - ld0, 0);
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_tag", rsp_tag, 4'd5);
    rsp_ready = 1'b1;
    tick();
    chk("bp_ld_gap1", core_ld, 1'b0);
    tick();
    chk("bp_ld_gap2", core_ld, 1'b1);
    drain(60);

    // Flush during WAIT with three queued behind the head
    core_lat  = 15;
    rsp_ready = 1'b1;
    base = rsp_tags.size();
    for (int i = 0; i < DEPTH; i++) push_req(4'(8 + i), rnd128(), rnd128());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_occ", occupancy, 3'd1);
    ld0 = ld_cnt;
    drain(60);
    repeat (5) tick();
    chk("flush_no_ld", ld_cnt - ld0, 0);
    chk("flush_rsp_count", rsp_tags.size() - base, 1);
    if (rsp_tags.size() > base) chk("flush_rsp_tag", rsp_tags[base], 4'd8);

`ifdef AES_INSN_TIMEOUT_EN
    // Watchdog: core never answers
    core_mute = 1'b1;
    rsp_ready = 1'b0;
    push_req(4'd12, rnd128(), rnd128());
    tick();
    chk("to_ld", core_ld, 1'b1);
    tick();
    n = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      tick();
      n++;
    end
    chk("to_wait_cycles", n, 64);
    chk("to_err", rsp_err, 1'b1);
    chk("to_text", rsp_text, 128'h0);
    chk("to_tag", rsp_tag, 4'd12);
    exp_timeout = 1'b1;
    rsp_ready   = 1'b1;
    tick();
    exp_timeout = 1'b0;
    core_mute   = 1'b0;
    inj_done    = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    chk("to_late_done", rsp_valid, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_tag   = 4'($urandom);
      req_key   = rnd128();
      req_text  = rnd128();
      flush     = ($urandom_range(0, 24) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      core_lat  = $urandom_range(1, 6);
      tick();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    drain(400);

    // Asynchronous reset while WAITing
    core_lat  = 20;
    rsp_ready = 1'b1;
    push_req(4'd7, rnd128(), rnd128());
    repeat (4) tick();
    chk("ar_inflight", occupancy, 3'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_req_ready", req_ready, 1'b1);
    chk("ar_core_ld", core_ld, 1'b0);
    chk("ar_core_key", core_key, 128'h0);
    chk("ar_core_text", core_text, 128'h0);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_rsp_err", rsp_err, 1'b0);
    chk("ar_occupancy", occupancy, 3'd0);
    sb.delete();
    in_flight = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    spur = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid) spur++;
    end
    chk("ar_no_rsp", spur, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
